// File: rtl/conv_wload_pkg.sv
// ---------------------------------------------------------------------------
// conv_wload_pkg
// Shared types and constants for the convolution weight loader.
//   - wload_state_e : loader FSM states (ZFILL exists only when the
//                     CONV_WLOAD_ZERO_FILL_EN macro is defined)
//   - BANK_IDX_W    : bank-index width for the default 16-bank build
//   - bank_idx_width: bank-index width for an arbitrary bank count
// ---------------------------------------------------------------------------
package conv_wload_pkg;

    localparam int DIMENSION_DEFAULT = 16;
    localparam int BANK_IDX_W        = $clog2(DIMENSION_DEFAULT);

    // A single bank still needs a 1-bit index so the counter has a width.
    function automatic int bank_idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

`ifdef CONV_WLOAD_ZERO_FILL_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ACK      = 3'd2,
        WAIT_LOW = 3'd3,
        ZFILL    = 3'd4
    } wload_state_e;
`else
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ACK      = 3'd2,
        WAIT_LOW = 3'd3
    } wload_state_e;
`endif

endpackage

// File: rtl/conv_weight_loader_if.sv
// ---------------------------------------------------------------------------
// conv_weight_loader_if
// Weight stream feeding the loader.
//   tdata  : weight word (DW bits)
//   tvalid : source has a word
//   tready : loader accepts a word
//   tlast  : final word of a filter group
// Modports: master = stream source, slave = loader.
// ---------------------------------------------------------------------------
interface conv_weight_loader_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/conv_wload_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_wload_addr_gen
// Bank-major (bank_idx, addr) counter pair for the weight loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance one location
//   clr        : return to bank 0, address 0 (wins over en)
//   n          : words per bank (latched group size, must be non-zero)
//   bank_idx   : current bank
//   addr       : current address within the bank
//   is_final   : current location is the last of the group
// ---------------------------------------------------------------------------
module conv_wload_addr_gen
    import conv_wload_pkg::*;
#(
    parameter int Dimension      = 16,
    parameter int ADDRESS_LENGTH = 10,
    localparam int BW            = bank_idx_width(Dimension)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic [ADDRESS_LENGTH-1:0] n,
    output logic [BW-1:0]             bank_idx,
    output logic [ADDRESS_LENGTH-1:0] addr,
    output logic                      is_final
);

    localparam logic [ADDRESS_LENGTH-1:0] ONE_A     = ADDRESS_LENGTH'(1);
    localparam logic [BW-1:0]             ONE_B     = BW'(1);
    localparam logic [BW-1:0]             LAST_BANK = BW'(Dimension - 1);

    logic [ADDRESS_LENGTH-1:0] last_addr;
    logic                      addr_wrap;

    assign last_addr = n - ONE_A;
    assign addr_wrap = (addr == last_addr);
    assign is_final  = addr_wrap && (bank_idx == LAST_BANK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_idx <= '0;
            addr     <= '0;
        end else if (clr) begin
            bank_idx <= '0;
            addr     <= '0;
        end else if (en) begin
            if (addr_wrap) begin
                addr     <= '0;
                bank_idx <= bank_idx + ONE_B;
            end else begin
                addr <= addr + ONE_A;
            end
        end
    end

endmodule

// File: rtl/conv_weight_loader.sv
// ---------------------------------------------------------------------------
// conv_weight_loader
// Pulls one filter group of weights from a stream and writes it bank-major
// into Dimension weight BRAMs through port A, then pulses weight_ack.
//   clk, rst_n     : clock, asynchronous active-low reset
//   weight_req     : level request from conv control (held until ack)
//   weight_ack     : one-cycle pulse, group fully written
//   words_per_bank : words per bank, sampled when the request is accepted
//   s_axis         : weight stream (slave side)
//   ena_weight     : per-bank port-A enable (one-hot on a write)
//   wea_weight     : per-bank port-A write enable
//   addra_weight   : port-A address shared by all banks
//   dina_weight    : port-A write data shared by all banks
//   busy           : high outside IDLE
//   err_tlast      : sticky framing error, cleared on the next accept
// Build option: CONV_WLOAD_ZERO_FILL_EN -- an early tlast ends the stream and
// the remaining locations are written with zero before the ack.
// ---------------------------------------------------------------------------
module conv_weight_loader
    import conv_wload_pkg::*;
#(
    parameter int DW             = 16,
    parameter int Dimension      = 16,
    parameter int ADDRESS_LENGTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      weight_req,
    output logic                      weight_ack,
    input  logic [ADDRESS_LENGTH-1:0] words_per_bank,
    conv_weight_loader_if.slave       s_axis,
    output logic [Dimension-1:0]      ena_weight,
    output logic [Dimension-1:0]      wea_weight,
    output logic [ADDRESS_LENGTH-1:0] addra_weight,
    output logic [DW-1:0]             dina_weight,
    output logic                      busy,
    output logic                      err_tlast
);

    localparam int BW = bank_idx_width(Dimension);
    localparam logic [Dimension-1:0] BANK0_ONEHOT = Dimension'(1);

    wload_state_e              state, state_nxt;
    logic [ADDRESS_LENGTH-1:0] n_lat;
    logic [BW-1:0]             bank_idx;
    logic [ADDRESS_LENGTH-1:0] addr;
    logic                      is_final;

    logic                      accept_req;
    logic                      cnt_en;
    logic                      wr_fire;
    logic [DW-1:0]             wr_data;
    logic                      err_set;
    logic                      tready;

    logic [Dimension-1:0]      ena_p1;
    logic [Dimension-1:0]      wea_p1;
    logic [ADDRESS_LENGTH-1:0] addra_p1;
    logic [DW-1:0]             dina_p1;
    logic                      ack_p1;
    logic                      err_q;

    conv_wload_addr_gen #(
        .Dimension      (Dimension),
        .ADDRESS_LENGTH (ADDRESS_LENGTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .clr      (accept_req),
        .n        (n_lat),
        .bank_idx (bank_idx),
        .addr     (addr),
        .is_final (is_final)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept_req = 1'b0;
        cnt_en     = 1'b0;
        wr_fire    = 1'b0;
        wr_data    = s_axis.tdata;
        err_set    = 1'b0;
        tready     = 1'b0;
        case (state)
            IDLE: begin
                if (weight_req) begin
                    accept_req = 1'b1;
                    // An empty group skips straight to the acknowledge.
                    state_nxt  = (words_per_bank == '0) ? ACK : LOAD;
                end
            end
            LOAD: begin
                tready = 1'b1;
                if (s_axis.tvalid) begin
                    cnt_en  = 1'b1;
                    wr_fire = 1'b1;
                    if (is_final) begin
                        err_set   = !s_axis.tlast;
                        state_nxt = ACK;
                    end else if (s_axis.tlast) begin
                        err_set = 1'b1;
`ifdef CONV_WLOAD_ZERO_FILL_EN
                        state_nxt = ZFILL;
`endif
                    end
                end
            end
`ifdef CONV_WLOAD_ZERO_FILL_EN
            ZFILL: begin
                // One zero word per cycle, same bank-major order as the stream.
                cnt_en  = 1'b1;
                wr_fire = 1'b1;
                wr_data = '0;
                if (is_final) begin
                    state_nxt = ACK;
                end
            end
`endif
            ACK: begin
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                // Requester may still hold req for a cycle after seeing ack.
                if (!weight_req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept_req) begin
                n_lat <= words_per_bank;
            end
            if (accept_req) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // ---- p1: registered port-A write and acknowledge ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_p1   <= '0;
            wea_p1   <= '0;
            addra_p1 <= '0;
            dina_p1  <= '0;
            ack_p1   <= 1'b0;
        end else begin
            ena_p1 <= wr_fire ? (BANK0_ONEHOT << bank_idx) : '0;
            wea_p1 <= wr_fire ? (BANK0_ONEHOT << bank_idx) : '0;
            if (wr_fire) begin
                addra_p1 <= addr;
                dina_p1  <= wr_data;
            end
            ack_p1 <= (state == ACK);
        end
    end

    assign s_axis.tready = tready;
    assign ena_weight    = ena_p1;
    assign wea_weight    = wea_p1;
    assign addra_weight  = addra_p1;
    assign dina_weight   = dina_p1;
    assign weight_ack    = ack_p1;
    assign busy          = (state != IDLE);
    assign err_tlast     = err_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_conv_weight_loader
// Directed sequence with randomized data/gaps for conv_weight_loader.
// Honours CONV_WLOAD_ZERO_FILL_EN for the early-tlast expectations.
// ---------------------------------------------------------------------------
module tb_conv_weight_loader;

    localparam int DW   = 16;
    localparam int DIM  = 16;
    localparam int AL   = 10;
    localparam int MAXA = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          weight_req = 1'b0;
    logic          weight_ack;
    logic [AL-1:0] words_per_bank = '0;
    logic [DIM-1:0] ena_weight, wea_weight;
    logic [AL-1:0] addra_weight;
    logic [DW-1:0] dina_weight;
    logic          busy, err_tlast;

    conv_weight_loader_if #(.DW(DW)) s_axis_if ();

    conv_weight_loader #(.DW(DW), .Dimension(DIM), .ADDRESS_LENGTH(AL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .weight_req     (weight_req),
        .weight_ack     (weight_ack),
        .words_per_bank (words_per_bank),
        .s_axis         (s_axis_if.slave),
        .ena_weight     (ena_weight),
        .wea_weight     (wea_weight),
        .addra_weight   (addra_weight),
        .dina_weight    (dina_weight),
        .busy           (busy),
        .err_tlast      (err_tlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state: BRAM image, write log statistics, ack statistics.
    logic [DW-1:0] mem [DIM][MAXA];
    logic [DW-1:0] beat [DIM*MAXA];
    int cur_n = 1;
    int wr_count, order_err, illegal, ack_count, ack_cyc, last_wr_cyc;
    bit tready_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Passive observer of the BRAM port and ack.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_axis_if.tready) tready_seen = 1'b1;
            if (ena_weight != '0 || wea_weight != '0) begin
                if (ena_weight != wea_weight || $countones(ena_weight) != 1 ||
                    addra_weight >= MAXA || cur_n == 0) begin
                    illegal++;
                end else begin
                    int b;
                    b = 0;
                    for (int i = 0; i < DIM; i++) if (ena_weight[i]) b = i;
                    if (b != wr_count / cur_n || int'(addra_weight) != wr_count % cur_n)
                        order_err++;
                    mem[b][addra_weight] = dina_weight;
                end
                wr_count++;
                last_wr_cyc = cyc;
            end
            if (weight_ack) begin
                ack_count++;
                ack_cyc = cyc;
            end
        end
    end

    task automatic clear_model(input int n);
        cur_n = n;
        wr_count = 0; order_err = 0; illegal = 0; ack_count = 0;
        ack_cyc = -1; last_wr_cyc = -1; tready_seen = 1'b0;
        for (int b = 0; b < DIM; b++)
            for (int a = 0; a < MAXA; a++) mem[b][a] = 'x;
    endtask

    // gaps: 0 none, 1 alternate idle cycle, 2 random 0..2 idle cycles
    task automatic send_beats(input int n_beats, input int tlast_at, input int gaps,
                              input bit rnd, output int timeouts);
        timeouts = 0;
        for (int k = 0; k < n_beats; k++) begin
            int idle;
            bit acc;
            int guard;
            idle = (gaps == 1) ? 1 : (gaps == 2) ? int'($urandom_range(0, 2)) : 0;
            beat[k] = rnd ? DW'($urandom) : DW'(k);
            s_axis_if.tvalid = 1'b0;
            repeat (idle) begin @(posedge clk); #1; end
            s_axis_if.tdata  = beat[k];
            s_axis_if.tlast  = (k == tlast_at);
            s_axis_if.tvalid = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = s_axis_if.tready;
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) timeouts++;
            // Group size is latched at accept; later changes must not matter.
            if (k == 0) words_per_bank = AL'($urandom_range(5, 900));
        end
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
    endtask

    task automatic wait_ack(output bit seen);
        int guard;
        guard = 0;
        while (ack_count == 0 && guard < 100) begin @(posedge clk); #1; guard++; end
        seen = (ack_count != 0);
    endtask

    // One complete request/stream/ack transaction plus its checks.
    task automatic run_load(input string tag, input int n, input int n_beats,
                            input int tlast_at, input int gaps, input bit rnd,
                            input int valid_beats, input bit exp_err);
        int to;
        bit seen;
        int bad;
        clear_model(n);
        words_per_bank = AL'(n);
        weight_req = 1'b1;
        send_beats(n_beats, tlast_at, gaps, rnd, to);
        wait_ack(seen);
        check({tag, "_stream_timeouts"}, 64'(to), 64'd0);
        check({tag, "_ack_seen"}, 64'(seen), 64'd1);
        weight_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bad = 0;
        for (int b = 0; b < DIM; b++)
            for (int a = 0; a < n; a++) begin
                int idx;
                logic [DW-1:0] exp;
                idx = b * n + a;
                exp = (idx < valid_beats) ? beat[idx] : '0;
                if (mem[b][a] !== exp) bad++;
            end
        check({tag, "_mem_mismatches"}, 64'(bad), 64'd0);
        check({tag, "_write_count"}, 64'(wr_count), 64'(DIM * n));
        check({tag, "_write_order_errors"}, 64'(order_err + illegal), 64'd0);
        check({tag, "_ack_pulses"}, 64'(ack_count), 64'd1);
        check({tag, "_ack_after_last_write"}, 64'(ack_cyc), 64'(last_wr_cyc + 1));
        check({tag, "_err_tlast"}, 64'(err_tlast), 64'(exp_err));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int req_cyc;
        bit seen;
        int to;
        int n_rnd;
        s_axis_if.tdata = '0;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ena", 64'(ena_weight), 64'd0);
        check("rst_wea", 64'(wea_weight), 64'd0);
        check("rst_addra", 64'(addra_weight), 64'd0);
        check("rst_dina", 64'(dina_weight), 64'd0);
        check("rst_tready", 64'(s_axis_if.tready), 64'd0);
        check("rst_ack", 64'(weight_ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_tlast), 64'd0);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("idle_busy", 64'(busy), 64'd0);

        // Basic load: data = k, tlast on the final beat
        run_load("basic", 3, 48, 47, 0, 1'b0, 48, 1'b0);

        // Back-pressure: tvalid alternating
        run_load("bpress", 3, 48, 47, 1, 1'b0, 48, 1'b0);

        // Zero-size group
        clear_model(0);
        words_per_bank = '0;
        weight_req = 1'b1;
        req_cyc = cyc;
        wait_ack(seen);
        check("zero_ack_seen", 64'(seen), 64'd1);
        check("zero_ack_latency", 64'(ack_cyc - req_cyc), 64'd2);
        repeat (5) begin @(posedge clk); #1; end
        check("zero_hold_busy", 64'(busy), 64'd1);
        check("zero_no_retrigger", 64'(ack_count), 64'd1);
        check("zero_no_tready", 64'(tready_seen), 64'd0);
        check("zero_no_writes", 64'(wr_count), 64'd0);
        weight_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("zero_busy_after", 64'(busy), 64'd0);

        // Early tlast on beat 20
`ifdef CONV_WLOAD_ZERO_FILL_EN
        run_load("early", 3, 21, 20, 0, 1'b1, 21, 1'b1);
`else
        run_load("early", 3, 48, 20, 0, 1'b1, 48, 1'b1);
`endif

        // Missing tlast on the final beat
        run_load("notlast", 3, 48, -1, 0, 1'b1, 48, 1'b1);

        // Random size/data/gaps; err_tlast must be cleared by the new accept
        n_rnd = int'($urandom_range(1, 4));
        run_load("random", n_rnd, DIM * n_rnd, DIM * n_rnd - 1, 2, 1'b1, DIM * n_rnd, 1'b0);

        // Reset in the middle of a load
        clear_model(3);
        words_per_bank = AL'(3);
        weight_req = 1'b1;
        send_beats(10, -1, 0, 1'b1, to);
        check("midrst_stream_timeouts", 64'(to), 64'd0);
        s_axis_if.tvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ena", 64'(ena_weight), 64'd0);
        check("midrst_wea", 64'(wea_weight), 64'd0);
        check("midrst_addra", 64'(addra_weight), 64'd0);
        check("midrst_dina", 64'(dina_weight), 64'd0);
        check("midrst_tready", 64'(s_axis_if.tready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        s_axis_if.tvalid = 1'b0;
        weight_req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("midrst_no_ack", 64'(ack_count), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);
        run_load("reload", 2, 32, 31, 2, 1'b1, 32, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/conv_weight_loader.md
Name: conv_weight_loader

Overview:
- Upstream feeder for the 1D-conv control wrapper's weight-update handshake.
- When the conv control asserts weight_req, the block pulls one filter-group of weights from a streaming source and writes them into the Dimension banked weight BRAMs through port A.
- It then returns a single-cycle weight_ack.
- Port B of the same BRAMs is read by the conv datapath; this block only writes.

Parameters:
- DW, 16, weight word width.
- Dimension, 16, number of weight BRAM banks (systolic columns); power of two.
- ADDRESS_LENGTH, 10, BRAM address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- weight_req  in  1  level request from conv control; held until weight_ack is seen.
- weight_ack  out  1  one-cycle pulse: group fully written.
- words_per_bank  in  ADDRESS_LENGTH  words per bank (kernel_size*input_channels); sampled at request accept.
- s_axis_tdata  in  DW  weight word.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  loader ready.
- s_axis_tlast  in  1  marks final word of group.
- ena_weight  out  Dimension  per-bank port-A enable.
- wea_weight  out  Dimension  per-bank port-A write enable.
- addra_weight  out  ADDRESS_LENGTH  port-A address (shared by all banks).
- dina_weight  out  DW  port-A write data (shared).
- busy  out  1  high outside IDLE.
- err_tlast  out  1  sticky framing error; cleared on next request accept.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-load aborts immediately. Partially written BRAM contents are undefined. No ack is issued.
- FSM states: IDLE, LOAD, ACK, WAIT_LOW.
- IDLE -> LOAD: on weight_req=1.
  - Latch words_per_bank into N.
  - Clear bank_idx, addr and err_tlast.
- IDLE -> ACK: taken instead of LOAD if the latched N==0. No beats are consumed.
- LOAD:
  - s_axis_tready=1.
  - Each accepted beat (tvalid & tready) writes to bank bank_idx at address addr.
- Write timing:
  - Write outputs are registered: 1-cycle latency from the accepted beat to ena/wea one-hot[bank_idx], addra=addr, dina=tdata.
  - ena/wea are 0 in any cycle without a beat accepted in the previous cycle.
- Ordering is bank-major:
  - addr increments each beat.
  - When addr==N-1, addr wraps to 0 and bank_idx increments.
- The final beat is bank_idx==Dimension-1 and addr==N-1.
  - s_axis_tready drops in the cycle after the final beat.
  - State goes to ACK. The final write occurs in that ACK cycle.
- tlast checking:
  - tlast must coincide with the final beat.
  - tlast missing on the final beat sets err_tlast.
  - tlast on a non-final beat (early tlast) sets err_tlast; behaviour otherwise per the Optional Feature.
- ACK: weight_ack=1 for exactly one cycle, then go to WAIT_LOW.
- WAIT_LOW: stay until weight_req==0, then go to IDLE. This prevents retrigger when the requester holds req for one extra cycle.
- Back-pressure: tvalid gaps stall the counters; there is no timeout.
- busy=1 in LOAD, ACK and WAIT_LOW.
- Width rules:
  - bank_idx is $clog2(Dimension) bits.
  - Counter comparisons use the latched N; words_per_bank changes mid-load are ignored.

Optional Feature:
- Macro: CONV_WLOAD_ZERO_FILL_EN.
- Defined:
  - On early tlast, the beat is written and err_tlast is set.
  - tready drops. The FSM writes zero to every remaining (bank, addr) location, one per cycle, in the same order.
  - Then ACK.
- Undefined: early tlast only sets err_tlast. Loading continues consuming beats until the counted final beat.

Decomposition:
- Package conv_wload_pkg holds:
  - the state enum (IDLE, LOAD, ACK, WAIT_LOW; ZFILL only under the macro);
  - a localparam for the bank-index width.
- One natural sub-module: conv_wload_addr_gen. It holds the bank_idx/addr counter pair with wrap and final detection. It has inputs en, clr and N, and outputs bank_idx, addr and is_final.
- The FSM and registered write stage stay in the top.

Test Plan:
- Basic load: Dimension=16, words_per_bank=3, 48 beats with data=k, tlast on beat 47.
  - Bank b, address a holds 3b+a.
  - weight_ack is a single pulse 1 cycle after the last write.
  - err_tlast=0.
- Back-pressure: same load with tvalid toggled 1-0-1-0 throughout.
  - Identical BRAM contents.
  - No writes in stalled cycles.
  - Ack after 48 beats.
- Zero size: words_per_bank=0, weight_req=1.
  - No tready, no writes.
  - Ack 2 cycles after req.
  - FSM waits in WAIT_LOW until req=0.
- Framing errors:
  - tlast on beat 20 of 48 -> err_tlast=1.
  - Without macro: loading continues to beat 47, then ack.
  - With CONV_WLOAD_ZERO_FILL_EN: beats 21..47 write 0, then ack.
  - Missing tlast on beat 47 -> err_tlast=1, ack still issued.
- Reset mid-load: assert rst_n=0 after 10 beats.
  - All outputs 0 asynchronously, no ack.
  - A new req after reset reloads from bank 0, address 0.
